// File: rtl/hc595_pkg.sv
// Shared types and defaults for the 74HC595 serial output stage.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEFAULT  = 16;
  localparam int unsigned CLK_DIV_DEFAULT = 4;
  localparam bit          MSB_FIRST       = 1'b1;

endpackage

// File: rtl/hc595_tick_gen.sv
// Divide counter: one-cycle tick every CLK_DIV clk cycles while enabled, cleared when disabled.
module hc595_tick_gen
  import hc595_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned DIV_W = 8;

  logic [DIV_W-1:0] div_cnt_q;

  assign tick_c = en && (div_cnt_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else if (!en || tick_c) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/hc595_shift_driver.sv
// Serialises one parallel frame into daisy-chained 74HC595s and latches it with st_cp.
module hc595_shift_driver
  import hc595_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  output logic              ready,
  output logic              done,
  output logic              sh_cp,
  output logic              st_cp,
  output logic              ds
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shifted_c;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sh_cp_q, sh_cp_d;
  logic              st_cp_q, st_cp_d;
  logic              ds_q, ds_d;
  logic              done_q, done_d;
  logic              tick_c;
  logic              accept_c;
  logic              last_bit_c;

  // Bit that goes on the wire first for a given register image.
  function automatic logic head(input logic [DATA_W-1:0] f);
    return MSB_FIRST ? f[DATA_W-1] : f[0];
  endfunction

  hc595_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q != IDLE),
    .tick_c (tick_c)
  );

  assign ready      = (state_q == IDLE);
  assign accept_c   = load && ready;
  assign last_bit_c = (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign shifted_c  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  assign done  = done_q;
  assign sh_cp = sh_cp_q;
  assign st_cp = st_cp_q;
  assign ds    = ds_q;

  // State and pin registers; reset aborts a frame without pulsing st_cp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sh_cp_q   <= 1'b0;
      st_cp_q   <= 1'b0;
      ds_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sh_cp_q   <= sh_cp_d;
      st_cp_q   <= st_cp_d;
      ds_q      <= ds_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: the last sh_cp fall moves to LATCH, the next tick closes the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = SHIFT;
      SHIFT:   if (tick_c && sh_cp_q && last_bit_c) state_d = LATCH;
      LATCH:   if (tick_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin and datapath next values; ds only moves on sh_cp falls for symmetric setup/hold.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sh_cp_d   = sh_cp_q;
    st_cp_d   = st_cp_q;
    ds_d      = ds_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sh_cp_d = 1'b0;
        st_cp_d = 1'b0;
        if (accept_c) begin
          shreg_d   = data;
          ds_d      = head(data);
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (!sh_cp_q) begin
            sh_cp_d = 1'b1;
          end else begin
            sh_cp_d   = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (last_bit_c) begin
              st_cp_d = 1'b1;
            end else begin
              shreg_d = shifted_c;
              ds_d    = head(shifted_c);
            end
          end
        end
      end
      LATCH: begin
        if (tick_c) begin
          st_cp_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        sh_cp_d = 1'b0;
        st_cp_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hc595_shift_driver.sv
// Bench for hc595_shift_driver: cycle-exact pin model plus a frame scoreboard fed by a ds sampler.
module tb_hc595_shift_driver;

  localparam int DW   = 16;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    load_v;
  logic [DW-1:0] data0, data1;
  logic [1:0]    ready_v, done_v, sh_v, st_v, ds_v;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  int            done_cnt[2];
  int            since_ds[2];
  int            since_rise[2];
  int            nbits[2];
  logic [DW-1:0] coll[2];
  logic          prev_sh[2], prev_st[2], prev_ds[2];
  int            mdiv;
  logic [DW-1:0] mexp;
  logic          mhas;

  always #5 clk = ~clk;

  hc595_shift_driver #(.DATA_W(DW), .CLK_DIV(DIV0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data(data0), .load(load_v[0]), .ready(ready_v[0]),
    .done(done_v[0]), .sh_cp(sh_v[0]), .st_cp(st_v[0]), .ds(ds_v[0])
  );

  hc595_shift_driver #(.DATA_W(DW), .CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data(data1), .load(load_v[1]), .ready(ready_v[1]),
    .done(done_v[1]), .sh_cp(sh_v[1]), .st_cp(st_v[1]), .ds(ds_v[1])
  );

  // Expected {ready, sh_cp, st_cp, done} j cycles after the accepting edge.
  function automatic logic [3:0] exp_pins(input int j, input int div);
    int  busy;
    logic r, s, t, d;
    busy = (2 * DW + 1) * div;
    s = (j < 2 * DW * div) && (((j / div) % 2) == 1);
    t = (j >= 2 * DW * div) && (j < busy);
    d = (j == busy);
    r = (j >= busy);
    return {r, s, t, d};
  endfunction

  // Pin sampler: collects ds on sh_cp rises, scores frames on st_cp rises, checks setup/hold.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mdiv = (i == 0) ? DIV0 : DIV1;
      if (rst_n !== 1'b1) begin
        nbits[i]      = 0;
        coll[i]       = '0;
        since_ds[i]   = 1000;
        since_rise[i] = 1000;
      end else begin
        if (since_ds[i] < 1000) since_ds[i]++;
        if (since_rise[i] < 1000) since_rise[i]++;
        if (ds_v[i] !== prev_ds[i]) begin
          checks++;
          if (since_rise[i] < mdiv) begin
            failures++;
            $display("FAIL hold_ds[%0d]: ds moved %0d cycles after sh_cp rise, need >= %0d", i, since_rise[i], mdiv);
          end
          since_ds[i] = 0;
        end
        if (sh_v[i] === 1'b1 && prev_sh[i] === 1'b0) begin
          checks++;
          if (since_ds[i] < mdiv) begin
            failures++;
            $display("FAIL setup_ds[%0d]: ds stable %0d cycles before sh_cp rise, need >= %0d", i, since_ds[i], mdiv);
          end
          since_rise[i] = 0;
          coll[i] = {coll[i][DW-2:0], ds_v[i]};
          nbits[i]++;
        end
        if (st_v[i] === 1'b1 && prev_st[i] === 1'b0) begin
          checks++;
          if (sh_v[i] !== 1'b0) begin
            failures++;
            $display("FAIL st_while_sh[%0d]: sh_cp=%b at st_cp rise, need 0", i, sh_v[i]);
          end
          mhas = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
          checks++;
          if (!mhas) begin
            failures++;
            $display("FAIL unexpected_latch[%0d]: st_cp pulsed with frame %h, none expected", i, coll[i]);
          end else begin
            if (i == 0) mexp = q0.pop_front();
            else        mexp = q1.pop_front();
            checks++;
            if (coll[i] !== mexp || nbits[i] != DW) begin
              failures++;
              $display("FAIL frame[%0d]: got %h in %0d rises, need %h in %0d rises", i, coll[i], nbits[i], mexp, DW);
            end
          end
          nbits[i] = 0;
          coll[i]  = '0;
        end
        if (done_v[i] === 1'b1) done_cnt[i]++;
      end
      prev_sh[i] = sh_v[i];
      prev_st[i] = st_v[i];
      prev_ds[i] = ds_v[i];
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    load_v = '0;
    data0  = '0;
    data1  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({ready_v[i], sh_v[i], st_v[i], ds_v[i], done_v[i]} !== 5'b10000) begin
          failures++;
          $display("FAIL reset_idle[%0d] cyc %0d: {ready,sh,st,ds,done}=%b need 10000", i, k,
                   {ready_v[i], sh_v[i], st_v[i], ds_v[i], done_v[i]});
        end
      end
    end
  endtask

  // Frame A55A at default divide, with a spurious load at E50 that must be ignored.
  task automatic test_single_frame();
    int dc;
    dc = done_cnt[0];
    @(posedge clk); #1;
    data0 = 16'hA55A; load_v[0] = 1'b1;
    q0.push_back(16'hA55A);
    @(posedge clk); #1;
    load_v[0] = 1'b0; data0 = 16'h1234;
    checks++;
    if ({ready_v[0], sh_v[0], st_v[0], ds_v[0], done_v[0]} !== 5'b00010) begin
      failures++;
      $display("FAIL accept_e0: {ready,sh,st,ds,done}=%b need 00010", {ready_v[0], sh_v[0], st_v[0], ds_v[0], done_v[0]});
    end
    for (int k = 1; k <= 180; k++) begin
      if (k == 50) begin load_v[0] = 1'b1; data0 = 16'hFFFF; end
      @(posedge clk); #1;
      if (k == 50) load_v[0] = 1'b0;
      checks++;
      if ({ready_v[0], sh_v[0], st_v[0], done_v[0]} !== exp_pins(k, DIV0)) begin
        failures++;
        $display("FAIL single_pins E%0d: {ready,sh,st,done}=%b need %b", k,
                 {ready_v[0], sh_v[0], st_v[0], done_v[0]}, exp_pins(k, DIV0));
      end
    end
    checks++;
    if (done_cnt[0] != dc + 1) begin
      failures++;
      $display("FAIL single_done_count: got %0d pulses need 1", done_cnt[0] - dc);
    end
  endtask

  // Load held high on the CLK_DIV=1 instance: frames accepted one cycle after each done.
  task automatic test_back_to_back();
    int dc, j, period;
    dc = done_cnt[1];
    period = (2 * DW + 1) * DIV1 + 1;
    @(posedge clk); #1;
    data1 = 16'h0001; load_v[1] = 1'b1;
    q1.push_back(16'h0001);
    q1.push_back(16'h8000);
    @(posedge clk); #1;
    data1 = 16'h8000;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (k == period) load_v[1] = 1'b0;
      j = (k < period) ? k : k - period;
      checks++;
      if ({ready_v[1], sh_v[1], st_v[1], done_v[1]} !== exp_pins(j, DIV1)) begin
        failures++;
        $display("FAIL b2b_pins E%0d: {ready,sh,st,done}=%b need %b", k,
                 {ready_v[1], sh_v[1], st_v[1], done_v[1]}, exp_pins(j, DIV1));
      end
    end
    checks++;
    if (done_cnt[1] != dc + 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d pulses need 2", done_cnt[1] - dc);
    end
  endtask

  // Reset at E40 aborts the frame silently; the following frame must still be clean.
  task automatic test_reset_mid_frame();
    int dc;
    logic [DW-1:0] dropped;
    dc = done_cnt[0];
    @(posedge clk); #1;
    data0 = 16'h3C96; load_v[0] = 1'b1;
    q0.push_back(16'h3C96);
    @(posedge clk); #1;
    load_v[0] = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready_v[0], sh_v[0], st_v[0], ds_v[0], done_v[0]} !== 5'b10000) begin
        failures++;
        $display("FAIL abort_pins cyc %0d: {ready,sh,st,ds,done}=%b need 10000", k,
                 {ready_v[0], sh_v[0], st_v[0], ds_v[0], done_v[0]});
      end
    end
    rst_n = 1'b1;
    dropped = q0.pop_front();
    checks++;
    if (done_cnt[0] != dc) begin
      failures++;
      $display("FAIL abort_done: got %0d pulses for aborted frame %h need 0", done_cnt[0] - dc, dropped);
    end
    @(posedge clk); #1;
    data0 = 16'hC3A5; load_v[0] = 1'b1;
    q0.push_back(16'hC3A5);
    @(posedge clk); #1;
    load_v[0] = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready_v[0], sh_v[0], st_v[0], done_v[0]} !== exp_pins(k, DIV0)) begin
        failures++;
        $display("FAIL after_abort_pins E%0d: {ready,sh,st,done}=%b need %b", k,
                 {ready_v[0], sh_v[0], st_v[0], done_v[0]}, exp_pins(k, DIV0));
      end
    end
    checks++;
    if (done_cnt[0] != dc + 1) begin
      failures++;
      $display("FAIL after_abort_done: got %0d pulses need 1", done_cnt[0] - dc);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    load_v = '0;
    data0  = '0;
    data1  = '0;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i]   = 0;
      since_ds[i]   = 1000;
      since_rise[i] = 1000;
      nbits[i]      = 0;
      coll[i]       = '0;
      prev_sh[i]    = 1'b0;
      prev_st[i]    = 1'b0;
      prev_ds[i]    = 1'b0;
    end
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d/%0d frames never latched, need 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
